// File: rtl/piano_pkg.sv
// piano_pkg: shared opcodes, FSM encoding and types for the piano voice scheduler
package piano_pkg;
   localparam int NUM_TRACKS = 4;
   localparam int NOTE_W = 6;
   localparam logic [7:0] CMD_ALL_OFF = 8'h00;
   localparam logic [7:0] CMD_ON_MASK = 8'h80;
   localparam logic [7:0] CMD_OFF_MASK = 8'hC0;
   localparam logic [7:0] CMD_OFF_VAL = 8'h40;
   localparam logic [7:0] CMD_NOTE_MASK = 8'h3F;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOOKUP = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   typedef logic [NOTE_W-1:0] note_t;
   typedef enum logic [1:0] {K_NOP, K_ON, K_OFF, K_ALL} kind_t;
   function automatic kind_t decode(input logic [7:0] b);
      return (b == CMD_ALL_OFF) ? K_ALL :
             ((b & CMD_NOTE_MASK) == 8'h00) ? K_NOP :
             ((b & CMD_ON_MASK) != 8'h00) ? K_ON :
             ((b & CMD_OFF_MASK) == CMD_OFF_VAL) ? K_OFF : K_NOP;
   endfunction
endpackage

// File: rtl/piano_voice_pick.sv
// piano_voice_pick: chooses the track for a note-on (retrigger, else lowest free, else LRU)
module piano_voice_pick
   import piano_pkg::*;
(
   input  logic [NUM_TRACKS-1:0][NOTE_W-1:0] tracks,
   input  logic [NUM_TRACKS-1:0][1:0]        ranks,
   input  note_t                             note,
   output logic                              hit,
   output logic                              free,
   output logic [1:0]                        idx
);
   logic any_hit, any_free;
   logic [1:0] hit_idx, free_idx, lru_idx;
   // Scan high to low so the lowest matching index wins
   always_comb begin
      any_hit = 1'b0;
      any_free = 1'b0;
      hit_idx = '0;
      free_idx = '0;
      lru_idx = '0;
      for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
         if (tracks[i] == note) begin
            any_hit = 1'b1;
            hit_idx = 2'(i);
         end
         if (tracks[i] == '0) begin
            any_free = 1'b1;
            free_idx = 2'(i);
         end
         if (ranks[i] == 2'd3) lru_idx = 2'(i);
      end
   end
   assign hit = any_hit;
   assign free = !any_hit && any_free;
   assign idx = any_hit ? hit_idx : any_free ? free_idx : lru_idx;
endmodule

// File: rtl/piano_voice_scheduler.sv
// piano_voice_scheduler: shares four note tracks between CPU note commands with LRU stealing and sustain timeout
module piano_voice_scheduler
   import piano_pkg::*;
#(
   parameter int TICK_DIV      = 100000,
   parameter int SUSTAIN_TICKS = 250
) (
   input  logic                  iFpgaClock,
   input  logic                  iCpuReset,
   input  logic                  iCmdValid,
   input  logic [7:0]            iCmdData,
   output logic                  oCmdReady,
   output logic [NOTE_W-1:0]     oTrack0,
   output logic [NOTE_W-1:0]     oTrack1,
   output logic [NOTE_W-1:0]     oTrack2,
   output logic [NOTE_W-1:0]     oTrack3,
   output logic [NUM_TRACKS-1:0] oBusyMask,
   output logic                  oStealPulse
);
   localparam int DIV_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [1:0] state;
   logic [7:0] cmd;
   kind_t kind;
   logic steal, hit, free, tick;
   logic [1:0] tgt, idx;
   logic [NUM_TRACKS-1:0][NOTE_W-1:0] tracks;
   logic [NUM_TRACKS-1:0][7:0] cnt;
   logic [NUM_TRACKS-1:0][1:0] ranks;
   logic [NUM_TRACKS-1:0] rank_seen;
   logic [DIV_W-1:0] div;
   note_t note;
   assign note = cmd[NOTE_W-1:0];
   assign tick = div == DIV_W'(TICK_DIV - 1);
   assign oCmdReady = state == ST_IDLE;
   assign {oTrack3, oTrack2, oTrack1, oTrack0} = tracks;
   piano_voice_pick u_pick (
      .tracks(tracks),
      .ranks(ranks),
      .note(note),
      .hit(hit),
      .free(free),
      .idx(idx)
   );
   // A track is busy whenever it holds a nonzero note
   always_comb begin
      for (int i = 0; i < NUM_TRACKS; i++) oBusyMask[i] = tracks[i] != '0;
   end
   // Command FSM, sustain divider and per-track state; commit writes land after tick expiry and win
   always_ff @(posedge iFpgaClock) begin
      if (!iCpuReset) begin
         state <= ST_IDLE;
         cmd <= '0;
         kind <= K_NOP;
         steal <= 1'b0;
         tgt <= '0;
         tracks <= '0;
         cnt <= '0;
         div <= '0;
         oStealPulse <= 1'b0;
         for (int i = 0; i < NUM_TRACKS; i++) ranks[i] <= 2'(i);
      end else begin
         div <= tick ? '0 : div + DIV_W'(1);
         oStealPulse <= 1'b0;
         state <= state == ST_IDLE ? (iCmdValid ? ST_LOOKUP : ST_IDLE) :
                  state == ST_LOOKUP ? ST_COMMIT : ST_IDLE;
         if (oCmdReady && iCmdValid) cmd <= iCmdData;
         if (state == ST_LOOKUP) begin
            kind <= decode(cmd);
            tgt <= idx;
            steal <= !hit && !free;
         end
         for (int i = 0; i < NUM_TRACKS; i++) begin
            if (tick && tracks[i] != '0) begin
               cnt[i] <= cnt[i] - 8'd1;
               if (cnt[i] == 8'd1) tracks[i] <= '0;
            end
         end
         if (state == ST_COMMIT && kind == K_ON) begin
            tracks[tgt] <= note;
            cnt[tgt] <= 8'(SUSTAIN_TICKS);
            oStealPulse <= steal;
            for (int i = 0; i < NUM_TRACKS; i++) begin
               if (2'(i) == tgt) ranks[i] <= '0;
               else if (ranks[i] < ranks[tgt]) ranks[i] <= ranks[i] + 2'd1;
            end
         end
         if (state == ST_COMMIT && kind == K_OFF) begin
            for (int i = 0; i < NUM_TRACKS; i++) begin
               if (tracks[i] == note) begin
                  tracks[i] <= '0;
                  cnt[i] <= '0;
               end
            end
         end
         if (state == ST_COMMIT && kind == K_ALL) begin
            tracks <= '0;
            cnt <= '0;
            for (int i = 0; i < NUM_TRACKS; i++) ranks[i] <= 2'(i);
         end
      end
   end
   // Collect which rank values are present so the permutation can be checked
   always_comb begin
      rank_seen = '0;
      for (int i = 0; i < NUM_TRACKS; i++) rank_seen[ranks[i]] = 1'b1;
   end
   assert property (@(posedge iFpgaClock) disable iff (!iCpuReset) rank_seen == 4'hF);
endmodule

// File: tb/tb_piano_voice_scheduler.sv
// tb_piano_voice_scheduler: directed table, corner sequences and randomized traffic against an LRU-queue model
module tb_piano_voice_scheduler;
   localparam int TD = 4;
   localparam int ST = 20;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic ready, pulse;
   logic [5:0] t0, t1, t2, t3;
   logic [3:0] busy;
   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;
   int m_note[4];
   int m_dead[4];
   int lru[$];
   int phase, m_tgt, m_edges, m_ticks;
   bit m_steal, m_pulse;
   logic [7:0] m_cmd;
   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] trk;
      bit          steal;
   } vec_t;
   vec_t tbl[15];

   piano_voice_scheduler #(.TICK_DIV(TD), .SUSTAIN_TICKS(ST)) dut (
      .iFpgaClock(clk),
      .iCpuReset(rst),
      .iCmdValid(valid),
      .iCmdData(data),
      .oCmdReady(ready),
      .oTrack0(t0),
      .oTrack1(t1),
      .oTrack2(t2),
      .oTrack3(t3),
      .oBusyMask(busy),
      .oStealPulse(pulse)
   );

   always #5 clk = ~clk;

   function automatic int kind_of(input logic [7:0] b);
      if (b == 8'h00) return 3;
      if (b[5:0] == 6'd0) return 0;
      if (b[7]) return 1;
      return b[6] ? 2 : 0;
   endfunction

   task automatic pick_target();
      int n;
      n = int'(m_cmd[5:0]);
      m_tgt = -1;
      foreach (m_note[i]) if (m_tgt < 0 && m_note[i] == n) m_tgt = i;
      foreach (m_note[i]) if (m_tgt < 0 && m_note[i] == 0) m_tgt = i;
      m_steal = m_tgt < 0;
      if (m_steal) m_tgt = lru[$];
   endtask

   task automatic commit();
      int n;
      n = int'(m_cmd[5:0]);
      case (kind_of(m_cmd))
         1: begin
            m_note[m_tgt] = n;
            m_dead[m_tgt] = m_ticks + ST;
            m_pulse = m_steal;
            for (int i = 0; i < lru.size(); i++) begin
               if (lru[i] == m_tgt) begin
                  lru.delete(i);
                  break;
               end
            end
            lru.push_front(m_tgt);
         end
         2: foreach (m_note[i]) if (m_note[i] == n) m_note[i] = 0;
         3: begin
            foreach (m_note[i]) m_note[i] = 0;
            lru = '{0, 1, 2, 3};
         end
         default: ;
      endcase
   endtask

   // Reference model: deadlines in absolute tick counts, recency as a most-recent-first queue
   always @(posedge clk) begin
      if (!rst) begin
         foreach (m_note[i]) begin
            m_note[i] = 0;
            m_dead[i] = 0;
         end
         lru = '{0, 1, 2, 3};
         phase = 0;
         m_pulse = 1'b0;
         m_edges = 0;
         m_ticks = 0;
      end else begin
         m_edges++;
         m_pulse = 1'b0;
         if (phase == 1) pick_target();
         if (m_edges % TD == 0) begin
            m_ticks++;
            foreach (m_note[i]) if (m_note[i] != 0 && m_dead[i] == m_ticks) m_note[i] = 0;
         end
         if (phase == 2) commit();
         if (phase == 2) phase = 0;
         else if (phase == 1) phase = 2;
         else if (valid) begin
            m_cmd = data;
            phase = 1;
         end
      end
   end

   // Every cycle, all outputs against the model
   always @(negedge clk) begin
      logic [29:0] exp_v, act_v;
      if (chk_en) begin
         exp_v = {6'(m_note[0]), 6'(m_note[1]), 6'(m_note[2]), 6'(m_note[3]),
                  m_note[3] != 0, m_note[2] != 0, m_note[1] != 0, m_note[0] != 0,
                  phase == 0, m_pulse};
         act_v = {t0, t1, t2, t3, busy, ready, pulse};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t got %h required %h", $time, act_v, exp_v);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int w;
      w = 0;
      while (!ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", 32'(ready), 32'(1));
      valid = 1'b1;
      data = b;
      @(negedge clk);
      valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   function automatic vec_t mk(input logic [7:0] c, input int a, input int b, input int d, input int e, input bit s);
      return '{cmd: c, trk: {6'(a), 6'(b), 6'(d), 6'(e)}, steal: s};
   endfunction

   function automatic logic [7:0] rand_cmd();
      int r, n;
      r = $urandom_range(0, 99);
      n = $urandom_range(1, 8);
      if (r < 60) return {1'b1, 1'($urandom_range(0, 1)), 6'(n)};
      if (r < 85) return {2'b01, 6'(n)};
      if (r < 90) return 8'h00;
      return 8'($urandom);
   endfunction

   initial begin
      int w;
      tbl[0] = mk(8'h85, 5, 0, 0, 0, 0);
      tbl[1] = mk(8'h87, 5, 7, 0, 0, 0);
      tbl[2] = mk(8'h89, 5, 7, 9, 0, 0);
      tbl[3] = mk(8'h47, 5, 0, 9, 0, 0);
      tbl[4] = mk(8'h00, 0, 0, 0, 0, 0);
      tbl[5] = mk(8'h81, 1, 0, 0, 0, 0);
      tbl[6] = mk(8'h82, 1, 2, 0, 0, 0);
      tbl[7] = mk(8'h83, 1, 2, 3, 0, 0);
      tbl[8] = mk(8'h84, 1, 2, 3, 4, 0);
      tbl[9] = mk(8'hC1, 1, 2, 3, 4, 0);
      tbl[10] = mk(8'h8A, 1, 10, 3, 4, 1);
      tbl[11] = mk(8'h80, 1, 10, 3, 4, 0);
      tbl[12] = mk(8'h40, 1, 10, 3, 4, 0);
      tbl[13] = mk(8'h3F, 1, 10, 3, 4, 0);
      tbl[14] = mk(8'h8B, 1, 10, 11, 4, 1);
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_tracks", 32'({t0, t1, t2, t3}), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_ready", 32'(ready), 32'(1));
      check("reset_steal", 32'(pulse), 32'(0));
      rst = 1'b1;
      foreach (tbl[i]) begin
         send(tbl[i].cmd);
         check($sformatf("vec%0d_tracks", i), 32'({t0, t1, t2, t3}), 32'(tbl[i].trk));
         check($sformatf("vec%0d_steal", i), 32'(pulse), 32'(tbl[i].steal));
         check($sformatf("vec%0d_ready", i), 32'(ready), 32'(1));
      end
      send(8'h00);
      send(8'h86);
      check("sustain_load", 32'(t0), 32'(6));
      repeat (40) @(negedge clk);
      check("sustain_mid", 32'(t0), 32'(6));
      send(8'h86);
      repeat (50) @(negedge clk);
      check("sustain_reloaded", 32'(t0), 32'(6));
      w = 0;
      while (t0 != 6'd0 && w < 120) begin
         @(negedge clk);
         w++;
      end
      check("sustain_expiry_window", 32'(w + 50 >= ST * TD - TD + 1 && w + 50 <= ST * TD), 32'(1));
      send(8'h81);
      send(8'h82);
      send(8'h83);
      send(8'h84);
      valid = 1'b1;
      data = 8'h8A;
      @(negedge clk);
      valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("midcmd_reset_tracks", 32'({t0, t1, t2, t3}), 32'(0));
      check("midcmd_reset_ready", 32'(ready), 32'(1));
      check("midcmd_reset_steal", 32'(pulse), 32'(0));
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("midcmd_no_commit", 32'({t0, t1, t2, t3}), 32'(0));
      for (int c = 0; c < 4000; c++) begin
         rst = $urandom_range(0, 599) != 0;
         valid = c < 2000 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 39) == 0;
         data = rand_cmd();
         @(negedge clk);
      end
      valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
